hongwai_rx: RTL and testbench

HONGWAI_RX -- requirements
Module: hongwai_rx

---
 rtl/hongwai_rx.sv | 196 +++++++++++++++++++
 tb/tb_hongwai_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hongwai_rx.sv
// hongwai_rx: decodes a two-field IR frame (lead, 35 bits, connect, 32 bits, stop)
// from a demodulated receiver output by measuring mark and period durations in clk cycles.
`timescale 1ns/1ps
module hongwai_rx #(
   parameter int CW      = 22,
   parameter int LM_MIN  = 800000,
   parameter int LM_MAX  = 1000000,
   parameter int LS_MIN  = 350000,
   parameter int LS_MAX  = 550000,
   parameter int MK_MIN  = 30000,
   parameter int MK_MAX  = 180000,
   parameter int PER_MIN = 80000,
   parameter int PER_MAX = 300000,
   parameter int CS_MIN  = 1800000,
   parameter int CS_MAX  = 2200000,
   parameter int BIT1_TH = 170000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ir_in,
   output logic [34:0] data35_out,
   output logic [31:0] data32_out,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        busy,
   output logic        led_out
);
   localparam int LW = CW + 2;
   localparam logic [LW-1:0] L_ONE     = LW'(1);
   localparam logic [LW-1:0] L_LM_MIN  = LW'(LM_MIN);
   localparam logic [LW-1:0] L_LM_MAX  = LW'(LM_MAX);
   localparam logic [LW-1:0] L_LS_MIN  = LW'(LS_MIN);
   localparam logic [LW-1:0] L_LS_MAX  = LW'(LS_MAX);
   localparam logic [LW-1:0] L_MK_MIN  = LW'(MK_MIN);
   localparam logic [LW-1:0] L_MK_MAX  = LW'(MK_MAX);
   localparam logic [LW-1:0] L_PER_MIN = LW'(PER_MIN);
   localparam logic [LW-1:0] L_PER_MAX = LW'(PER_MAX);
   localparam logic [LW-1:0] L_CS_MIN  = LW'(CS_MIN);
   localparam logic [LW-1:0] L_CS_MAX  = LW'(CS_MAX);
   localparam logic [LW-1:0] L_TH      = LW'(BIT1_TH);

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BITS35, S_CONN_SPACE, S_BITS32
   } state_t;

   state_t          r_state;
   logic            r_sync1, r_sync2, r_sync3;
   logic            r_fall, r_rise;
   logic [CW-1:0]   r_cnt;
   logic [LW-1:0]   r_mark_len;
   logic            r_in_space;
   logic [5:0]      r_bit_cnt;
   logic [34:0]     r_sh35;
   logic [31:0]     r_sh32;
   logic [34:0]     r_data35;
   logic [31:0]     r_data32;
   logic            r_valid, r_err, r_busy, r_led;

   logic [LW-1:0]   w_len;
   logic [LW-1:0]   w_per;
   logic            w_bit, w_mark_ok, w_per_ok, w_fail;

   // w_len is the length of the running segment including this cycle, so an edge
   // arriving L cycles after the previous one is judged against exactly L.
   assign w_len     = {2'b00, r_cnt} + L_ONE;
   assign w_per     = r_mark_len + w_len;
   assign w_bit     = (w_per >= L_TH);
   assign w_mark_ok = (w_len >= L_MK_MIN) && (w_len <= L_MK_MAX);
   assign w_per_ok  = (w_per >= L_PER_MIN) && (w_per <= L_PER_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_fall  <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= ir_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_fall  <= r_sync3 & ~r_sync2;
         r_rise  <= ~r_sync3 & r_sync2;
         if (r_fall | r_rise)
            r_cnt <= '0;
         else if (r_cnt != '1)
            r_cnt <= r_cnt + CW'(1);
      end
   end

   // A bad edge and a phase timeout land in the same cycle, so one flag covers both.
   always_comb begin
      w_fail = 1'b0;
      case (r_state)
         S_LEAD_MARK:  w_fail = r_rise ? !((w_len >= L_LM_MIN) && (w_len <= L_LM_MAX)) : (w_len > L_LM_MAX);
         S_LEAD_SPACE: w_fail = r_fall ? !((w_len >= L_LS_MIN) && (w_len <= L_LS_MAX)) : (w_len > L_LS_MAX);
         S_CONN_SPACE: w_fail = r_fall ? !((w_len >= L_CS_MIN) && (w_len <= L_CS_MAX)) : (w_len > L_CS_MAX);
         S_BITS35, S_BITS32: begin
            if (!r_in_space)
               w_fail = r_rise ? !w_mark_ok : (w_len > L_MK_MAX);
            else
               w_fail = r_fall ? !w_per_ok : (w_per > L_PER_MAX);
         end
         default: w_fail = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mark_len <= '0;
         r_in_space <= 1'b0;
         r_bit_cnt  <= '0;
         r_sh35     <= '0;
         r_sh32     <= '0;
         r_data35   <= '0;
         r_data32   <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_led      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (w_fail) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: if (r_fall) begin
                  r_state <= S_LEAD_MARK;
                  r_busy  <= 1'b1;
               end
               S_LEAD_MARK: if (r_rise) r_state <= S_LEAD_SPACE;
               S_LEAD_SPACE: if (r_fall) begin
                  r_state    <= S_BITS35;
                  r_bit_cnt  <= '0;
                  r_in_space <= 1'b0;
               end
               S_BITS35: begin
                  if (!r_in_space && r_rise) begin
                     if (r_bit_cnt == 6'd35) begin
                        r_state <= S_CONN_SPACE;
                     end else begin
                        r_mark_len <= w_len;
                        r_in_space <= 1'b1;
                     end
                  end else if (r_in_space && r_fall) begin
                     r_sh35     <= {r_sh35[33:0], w_bit};
                     r_bit_cnt  <= r_bit_cnt + 6'd1;
                     r_in_space <= 1'b0;
                  end
               end
               S_CONN_SPACE: if (r_fall) begin
                  r_state    <= S_BITS32;
                  r_bit_cnt  <= '0;
                  r_in_space <= 1'b0;
               end
               S_BITS32: begin
                  if (!r_in_space && r_rise) begin
                     r_mark_len <= w_len;
                     r_in_space <= 1'b1;
                  end else if (r_in_space && r_fall) begin
                     // The fall closing bit 32 is the stop mark: publish and go idle.
                     if (r_bit_cnt == 6'd31) begin
                        r_data35 <= r_sh35;
                        r_data32 <= {r_sh32[30:0], w_bit};
                        r_valid  <= 1'b1;
                        r_led    <= ~r_led;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                     end else begin
                        r_sh32     <= {r_sh32[30:0], w_bit};
                        r_bit_cnt  <= r_bit_cnt + 6'd1;
                        r_in_space <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign data35_out  = r_data35;
   assign data32_out  = r_data32;
   assign frame_valid = r_valid;
   assign frame_err   = r_err;
   assign busy        = r_busy;
   assign led_out     = r_led;
endmodule

// File: tb/tb_hongwai_rx.sv
// Directed bench for hongwai_rx. All IR timings are scaled by 1/2000 through the window
// parameters (9 ms lead mark -> 450 cycles, bit-1 threshold 170000 -> 85 cycles).
`timescale 1ns/1ps
module tb_hongwai_rx;
   localparam int CONN_MARK = 37;
   localparam int CONN_SPC  = 1000;
   localparam int STOP_MARK = 37;
   localparam int HANG_SPC  = 1500;
   localparam int FZM = 16, FZS = 26, FOM = 16, FOS = 72;

   logic        clk = 1'b0, rst = 1'b1, ir_in = 1'b1;
   logic [34:0] data35_out;
   logic [31:0] data32_out;
   logic        frame_valid, frame_err, busy, led_out;

   hongwai_rx #(
      .LM_MIN(400), .LM_MAX(500), .LS_MIN(175), .LS_MAX(275),
      .MK_MIN(15), .MK_MAX(90), .PER_MIN(40), .PER_MAX(150),
      .CS_MIN(900), .CS_MAX(1100), .BIT1_TH(85)
   ) dut (
      .clk(clk), .rst(rst), .ir_in(ir_in),
      .data35_out(data35_out), .data32_out(data32_out),
      .frame_valid(frame_valid), .frame_err(frame_err),
      .busy(busy), .led_out(led_out)
   );

   always #5 clk = ~clk;

   int cyc = 0, n_valid = 0, n_err = 0, n_both = 0, valid_cyc = 0, stop_cyc = 0;
   int n_checks = 0, n_errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid) begin
         n_valid   <= n_valid + 1;
         valid_cyc <= cyc;
      end
      if (frame_err) n_err <= n_err + 1;
      if (frame_valid && frame_err) n_both <= n_both + 1;
   end

   typedef struct {
      int          lm, ls, zm, zs, om, os;
      logic [34:0] d35;
      logic [31:0] d32;
      bit          ok;
   } vec_t;

   vec_t        tv[8];
   logic [34:0] exp_d35;
   logic [31:0] exp_d32;
   logic        exp_led;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Hold ir_in at lvl for n rising edges; inputs always change 1 ns after an edge.
   task automatic seg(input logic lvl, input int n);
      ir_in = lvl;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Plays one frame; stops driving (line idle high) as soon as a frame_err is seen.
   task automatic play_frame(input int lm, input int ls, input int zm, input int zs,
                             input int om, input int os, input logic [34:0] d35,
                             input logic [31:0] d32, input int hang_at);
      int   e0;
      logic b;
      e0 = n_err;
      seg(1'b0, lm);
      if (n_err != e0) begin ir_in = 1'b1; return; end
      seg(1'b1, ls);
      if (n_err != e0) begin ir_in = 1'b1; return; end
      for (int i = 34; i >= 0; i--) begin
         b = d35[i];
         seg(1'b0, b ? om : zm);
         if (n_err != e0) begin ir_in = 1'b1; return; end
         seg(1'b1, b ? os : zs);
         if (n_err != e0) begin ir_in = 1'b1; return; end
      end
      seg(1'b0, CONN_MARK);
      if (n_err != e0) begin ir_in = 1'b1; return; end
      seg(1'b1, CONN_SPC);
      if (n_err != e0) begin ir_in = 1'b1; return; end
      for (int i = 31; i >= 0; i--) begin
         b = d32[i];
         seg(1'b0, b ? om : zm);
         if (n_err != e0) begin ir_in = 1'b1; return; end
         seg(1'b1, (31 - i == hang_at) ? HANG_SPC : (b ? os : zs));
         if (n_err != e0) begin ir_in = 1'b1; return; end
      end
      stop_cyc = cyc;
      seg(1'b0, STOP_MARK);
      ir_in = 1'b1;
   endtask

   initial begin
      int          v0, e0;
      logic        led0;
      logic [34:0] fa35;
      logic [31:0] fa32;

      tv[0] = '{450, 225, 37, 23, 75, 37, 35'h5_5555_5555, 32'hA5A5_0F0F, 1'b1};
      tv[1] = '{350, 225, 37, 23, 75, 37, 35'h1_1111_1111, 32'h2222_2222, 1'b0};
      tv[2] = '{450, 225, 40, 44, 40, 45, 35'h1_2345_6789, 32'hDEAD_BEEF, 1'b1};
      tv[3] = '{450, 225, 20, 19, 75, 37, 35'h0_0000_0000, 32'h0000_0000, 1'b0};
      tv[4] = '{450, 225, 37, 23, 75, 76, 35'h7_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
      tv[5] = '{400, 275, 15, 25, 90, 60, 35'h0_F0F0_F0F1, 32'h1234_5678, 1'b1};
      tv[6] = '{500, 175, FZM, FZS, FOM, FOS, 35'h7_0000_000E, 32'h8000_0001, 1'b1};
      tv[7] = '{501, 225, 37, 23, 75, 37, 35'h3_3333_3333, 32'h4444_4444, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      seg(1'b1, 10);
      check("rst_d35", 64'(data35_out), 64'(0));
      check("rst_d32", 64'(data32_out), 64'(0));
      check("rst_valid", 64'(frame_valid), 64'(0));
      check("rst_err", 64'(frame_err), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_led", 64'(led_out), 64'(0));
      exp_d35 = '0;
      exp_d32 = '0;
      exp_led = 1'b0;

      for (int v = 0; v < 8; v++) begin
         v0 = n_valid;
         e0 = n_err;
         play_frame(tv[v].lm, tv[v].ls, tv[v].zm, tv[v].zs, tv[v].om, tv[v].os,
                    tv[v].d35, tv[v].d32, -1);
         seg(1'b1, 20);
         if (tv[v].ok) begin
            exp_d35 = tv[v].d35;
            exp_d32 = tv[v].d32;
            exp_led = ~exp_led;
            check("vec_latency", 64'(valid_cyc - stop_cyc), 64'(4));
         end
         check("vec_valid_cnt", 64'(n_valid - v0), 64'(tv[v].ok));
         check("vec_err_cnt", 64'(n_err - e0), 64'(!tv[v].ok));
         check("vec_d35", 64'(data35_out), 64'(exp_d35));
         check("vec_d32", 64'(data32_out), 64'(exp_d32));
         check("vec_led", 64'(led_out), 64'(exp_led));
         check("vec_busy", 64'(busy), 64'(0));
         $display("vector %0d: valid=%0d err=%0d d35=%h d32=%h led=%0b", v,
                  n_valid - v0, n_err - e0, data35_out, data32_out, led_out);
      end

      // Space stuck for 30 ms inside the 32-bit field.
      v0 = n_valid;
      e0 = n_err;
      play_frame(450, 225, 37, 23, 75, 37, 35'h5_5555_5555, 32'hFFFF_0000, 5);
      seg(1'b1, 20);
      check("hang_err_cnt", 64'(n_err - e0), 64'(1));
      check("hang_valid_cnt", 64'(n_valid - v0), 64'(0));
      check("hang_d35", 64'(data35_out), 64'(exp_d35));
      check("hang_d32", 64'(data32_out), 64'(exp_d32));
      check("hang_busy", 64'(busy), 64'(0));
      $display("stuck space: err=%0d valid=%0d", n_err - e0, n_valid - v0);

      // Reset during bit 20 of the 35-bit field, released while the mark is still low.
      v0 = n_valid;
      e0 = n_err;
      seg(1'b0, 450);
      check("busy_in_frame", 64'(busy), 64'(1));
      seg(1'b1, 225);
      for (int i = 0; i < 19; i++) begin
         seg(1'b0, 37);
         seg(1'b1, 23);
      end
      seg(1'b0, 20);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_d35", 64'(data35_out), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_led", 64'(led_out), 64'(0));
      exp_d35 = '0;
      exp_d32 = '0;
      exp_led = 1'b0;
      seg(1'b0, 17);
      seg(1'b1, 300);
      play_frame(450, 225, FZM, FZS, FOM, FOS, 35'h2_4924_9249, 32'h0BAD_F00D, -1);
      seg(1'b1, 20);
      check("midrst_err_cnt", 64'(n_err - e0), 64'(0));
      check("midrst_valid_cnt", 64'(n_valid - v0), 64'(1));
      check("midrst_d35_after", 64'(data35_out), 64'(35'h2_4924_9249));
      check("midrst_d32_after", 64'(data32_out), 64'(32'h0BAD_F00D));
      check("midrst_led_after", 64'(led_out), 64'(1));
      exp_led = 1'b1;
      $display("reset mid-frame: err=%0d valid=%0d d35=%h d32=%h", n_err - e0,
               n_valid - v0, data35_out, data32_out);

      // Two frames 5 ms apart.
      v0   = n_valid;
      led0 = led_out;
      fa35 = 35'h6_0F0F_1234;
      fa32 = 32'hCAFE_0001;
      play_frame(450, 225, FZM, FZS, FOM, FOS, fa35, fa32, -1);
      check("b2b_first_d35", 64'(data35_out), 64'(fa35));
      check("b2b_first_d32", 64'(data32_out), 64'(fa32));
      seg(1'b1, 250);
      play_frame(450, 225, FZM, FZS, FOM, FOS, 35'h1_8765_4321, 32'h5A5A_C3C3, -1);
      seg(1'b1, 20);
      check("b2b_valid_cnt", 64'(n_valid - v0), 64'(2));
      check("b2b_latency", 64'(valid_cyc - stop_cyc), 64'(4));
      check("b2b_second_d35", 64'(data35_out), 64'(35'h1_8765_4321));
      check("b2b_second_d32", 64'(data32_out), 64'(32'h5A5A_C3C3));
      check("b2b_led", 64'(led_out), 64'(led0));
      $display("back-to-back: valid=%0d d35=%h d32=%h led=%0b", n_valid - v0,
               data35_out, data32_out, led_out);

      check("valid_err_overlap", 64'(n_both), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
